// File: rtl/arvi_bus_pkg.sv
// Shared types and widths for the two-master bus arbiter.
package arvi_bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Request fields that travel from the owning master to the slave.
  typedef struct packed {
    logic              wr_en;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wr_data;
    logic [3:0]        byte_en;
    logic [6:0]        operation;
    logic              atomic;
  } bus_req_t;

endpackage

// File: rtl/arvi_bus_watchdog.sv
// Per-transaction cycle counter; flags the cycle in which an unacknowledged
// transfer has been owned for TIMEOUT cycles. TIMEOUT=0 disables the flag.
module arvi_bus_watchdog
  import arvi_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count owned cycles; cleared while idle and on every slave ack.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/arvi_bus_arbiter.sv
// Round-robin arbiter between the fetch port (m0) and data port (m1) onto a
// single bus slave, with ack-held grants, optional atomic lock and watchdog.
module arvi_bus_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int TIMEOUT     = 255,
  parameter int LOCK_ATOMIC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_bus_en,
  input  logic              i_m0_wr_en,
  input  logic [BUS_AW-1:0] i_m0_addr,
  input  logic [BUS_DW-1:0] i_m0_wr_data,
  input  logic [3:0]        i_m0_byte_en,
  input  logic [6:0]        i_m0_operation,
  input  logic              i_m0_atomic,
  output logic              o_m0_ack,
  output logic [BUS_DW-1:0] o_m0_rd_data,
  output logic              o_m0_err,
  input  logic              i_m1_bus_en,
  input  logic              i_m1_wr_en,
  input  logic [BUS_AW-1:0] i_m1_addr,
  input  logic [BUS_DW-1:0] i_m1_wr_data,
  input  logic [3:0]        i_m1_byte_en,
  input  logic [6:0]        i_m1_operation,
  input  logic              i_m1_atomic,
  output logic              o_m1_ack,
  output logic [BUS_DW-1:0] o_m1_rd_data,
  output logic              o_m1_err,
  output logic              o_bus_en,
  output logic              o_wr_en,
  output logic [BUS_AW-1:0] o_addr,
  output logic [BUS_DW-1:0] o_wr_data,
  output logic [3:0]        o_byte_en,
  output logic [6:0]        o_operation,
  output logic              o_atomic,
  input  logic              i_ack,
  input  logic [BUS_DW-1:0] i_rd_data,
  output logic [1:0]        o_grant
);

  arb_state_t state, state_nxt;
  logic       last_served, last_nxt;
  bus_req_t   req0, req1, req_own;
  logic       own0, own1, owned, owner_en;
  logic       ack_ok, wd_hit, abort;

  assign req0 = {i_m0_wr_en, i_m0_addr, i_m0_wr_data, i_m0_byte_en, i_m0_operation, i_m0_atomic};
  assign req1 = {i_m1_wr_en, i_m1_addr, i_m1_wr_data, i_m1_byte_en, i_m1_operation, i_m1_atomic};

  // Ownership is masked by reset so nothing is forwarded in the reset cycle.
  assign own0     = (state == OWN0) && !i_rst;
  assign own1     = (state == OWN1) && !i_rst;
  assign owned    = own0 || own1;
  assign owner_en = (own0 && i_m0_bus_en) || (own1 && i_m1_bus_en);
  assign req_own  = own1 ? req1 : (own0 ? req0 : '0);
  assign ack_ok   = owner_en && i_ack;
  // An ack in the timeout cycle wins; a dropped request is never aborted.
  assign abort    = wd_hit && owner_en && !i_ack;

  arvi_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (!owned || ack_ok),
    .enable  (owned),
    .timeout (wd_hit)
  );

  // State and round-robin history registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
    end
  end

  // Arbitration in IDLE; release on ack, drop or watchdog abort when owned.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_served;
    case (state)
      IDLE: begin
        if (i_m0_bus_en && (!i_m1_bus_en || last_served)) begin
          state_nxt = OWN0;
        end else if (i_m1_bus_en) begin
          state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!owner_en) begin
          state_nxt = IDLE;
        end else if (i_ack) begin
          last_nxt = (state == OWN1);
          if (!((LOCK_ATOMIC != 0) && req_own.atomic)) begin
            state_nxt = IDLE;
          end
        end else if (abort) begin
          last_nxt  = (state == OWN1);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Forward the owner's request to the slave and route the response back.
  always_comb begin
    o_bus_en     = owner_en && !abort;
    o_wr_en      = req_own.wr_en;
    o_addr       = req_own.addr;
    o_wr_data    = req_own.wr_data;
    o_byte_en    = req_own.byte_en;
    o_operation  = req_own.operation;
    o_atomic     = req_own.atomic;
    o_m0_ack     = own0 && (ack_ok || abort);
    o_m0_err     = own0 && abort;
    o_m0_rd_data = (own0 && !abort) ? i_rd_data : '0;
    o_m1_ack     = own1 && (ack_ok || abort);
    o_m1_err     = own1 && abort;
    o_m1_rd_data = (own1 && !abort) ? i_rd_data : '0;
    o_grant      = {own1, own0};
  end

endmodule

// File: tb/tb_arvi_bus_arbiter.sv
// Self-checking bench for arvi_bus_arbiter: directed scenarios followed by a
// randomized phase, all compared each cycle against a transaction-level model.
module tb_arvi_bus_arbiter;

  localparam int TO = 8;
  localparam int LA = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m_en [2];
  logic        m_we [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd [2];
  logic [3:0]  m_be [2];
  logic [6:0]  m_op [2];
  logic        m_at [2];
  logic        ack;
  logic [31:0] rd;

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic        bus_en, we, at;
  logic [31:0] addr, wdat;
  logic [3:0]  be;
  logic [6:0]  op;
  logic [1:0]  grant;

  arvi_bus_arbiter #(.TIMEOUT(TO), .LOCK_ATOMIC(LA)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_bus_en(m_en[0]), .i_m0_wr_en(m_we[0]), .i_m0_addr(m_addr[0]),
    .i_m0_wr_data(m_wd[0]), .i_m0_byte_en(m_be[0]), .i_m0_operation(m_op[0]),
    .i_m0_atomic(m_at[0]), .o_m0_ack(m0_ack), .o_m0_rd_data(m0_rd), .o_m0_err(m0_err),
    .i_m1_bus_en(m_en[1]), .i_m1_wr_en(m_we[1]), .i_m1_addr(m_addr[1]),
    .i_m1_wr_data(m_wd[1]), .i_m1_byte_en(m_be[1]), .i_m1_operation(m_op[1]),
    .i_m1_atomic(m_at[1]), .o_m1_ack(m1_ack), .o_m1_rd_data(m1_rd), .o_m1_err(m1_err),
    .o_bus_en(bus_en), .o_wr_en(we), .o_addr(addr), .o_wr_data(wdat),
    .o_byte_en(be), .o_operation(op), .o_atomic(at),
    .i_ack(ack), .i_rd_data(rd), .o_grant(grant)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 none), last served master, cycles owned.
  int own  = -1;
  int last = 1;
  int wd   = 0;

  // Scenario bookkeeping.
  int          rem [2];
  int          tix [2];
  logic [7:0]  at_pat [2];
  int          ack_delay = -1;
  bit          auto_mode = 1'b0;
  bit          fix_rd = 1'b0;
  int          n_bus, run0, err_len0;
  int          n_ack [2];
  int          n_err [2];
  logic        err_bus;
  logic [31:0] cap_m0_rd, cap_addr, cap_wd;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [1:0]  prev_grant = 2'b00;
  int          glog [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_bus = 0; run0 = 0; err_len0 = -1; err_bus = 1'bx;
    for (int i = 0; i < 2; i++) begin
      n_ack[i] = 0; n_err[i] = 0; tix[i] = 0; rem[i] = 0;
    end
    glog.delete();
  endtask

  task automatic drive_auto();
    for (int i = 0; i < 2; i++) begin
      m_en[i] = (rem[i] > 0);
      m_at[i] = m_en[i] ? at_pat[i][tix[i]] : 1'b0;
    end
    ack = (ack_delay >= 0) && (own >= 0) && m_en[own] && (wd == ack_delay);
    rd  = fix_rd ? 32'hDEADBEEF : $urandom;
  endtask

  // One clock: compare all outputs against the model, then advance the model.
  task automatic cycle();
    logic        e_bus, to, ak;
    logic        e_ack [2];
    logic        e_err [2];
    logic [31:0] e_rd [2];
    logic        e_we, e_at;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic [6:0]  e_op;
    logic [1:0]  e_grant;
    int          o;
    #1;
    o = own;
    e_bus = 0; to = 0; ak = 0; e_we = 0; e_at = 0; e_addr = 0; e_wd = 0;
    e_be = 0; e_op = 0; e_grant = 2'b00;
    for (int i = 0; i < 2; i++) begin
      e_ack[i] = 0; e_err[i] = 0; e_rd[i] = 0;
    end
    if (!rst && o >= 0) begin
      ak      = m_en[o] && ack;
      to      = (TO != 0) && m_en[o] && !ack && (wd == TO - 1);
      e_bus   = m_en[o] && !to;
      e_we    = m_we[o]; e_addr = m_addr[o]; e_wd = m_wd[o];
      e_be    = m_be[o]; e_op = m_op[o]; e_at = m_at[o];
      e_grant = (o == 0) ? 2'b01 : 2'b10;
      e_ack[o] = ak || to;
      e_err[o] = to;
      e_rd[o]  = to ? 32'h0 : rd;
    end
    check("bus_en", 32'(bus_en), 32'(e_bus));
    check("wr_en", 32'(we), 32'(e_we));
    check("addr", addr, e_addr);
    check("wr_data", wdat, e_wd);
    check("byte_en", 32'(be), 32'(e_be));
    check("operation", 32'(op), 32'(e_op));
    check("atomic", 32'(at), 32'(e_at));
    check("grant", 32'(grant), 32'(e_grant));
    check("m0_ack", 32'(m0_ack), 32'(e_ack[0]));
    check("m0_err", 32'(m0_err), 32'(e_err[0]));
    check("m0_rd", m0_rd, e_rd[0]);
    check("m1_ack", 32'(m1_ack), 32'(e_ack[1]));
    check("m1_err", 32'(m1_err), 32'(e_err[1]));
    check("m1_rd", m1_rd, e_rd[1]);
    // Observed statistics for scenario-level checks.
    if (bus_en === 1'b1) n_bus++;
    if (m0_ack === 1'b1) begin n_ack[0]++; cap_m0_rd = m0_rd; end
    if (m1_ack === 1'b1) n_ack[1]++;
    if (m1_err === 1'b1) n_err[1]++;
    run0 = (grant === 2'b01) ? run0 + 1 : 0;
    if (m0_err === 1'b1) begin n_err[0]++; err_len0 = run0; err_bus = bus_en; end
    if (grant === 2'b10 && bus_en === 1'b1) begin
      cap_we = we; cap_addr = addr; cap_wd = wdat; cap_be = be;
    end
    if (prev_grant === 2'b00 && grant !== 2'b00)
      glog.push_back((grant === 2'b01) ? 0 : (grant === 2'b10) ? 1 : 9);
    prev_grant = grant;
    if (auto_mode)
      for (int i = 0; i < 2; i++)
        if (e_ack[i]) begin rem[i]--; tix[i]++; end
    // Model next state.
    if (rst) begin
      own = -1; last = 1; wd = 0;
    end else if (o < 0) begin
      wd = 0;
      if (m_en[0] && (!m_en[1] || last == 1)) own = 0;
      else if (m_en[1]) own = 1;
    end else if (!m_en[o]) begin
      own = -1;
    end else if (ak) begin
      last = o; wd = 0;
      if (!(LA != 0 && m_at[o])) own = -1;
    end else if (to) begin
      last = o; own = -1;
    end else begin
      wd++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_auto(input string tag, input int budget);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < budget) begin
      drive_auto();
      cycle();
      n++;
      done = (rem[0] <= 0) && (rem[1] <= 0) && (own < 0);
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; ack = 1'b0;
    for (int i = 0; i < 2; i++) m_en[i] = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; rd = '0;
    for (int i = 0; i < 2; i++) begin
      m_en[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_wd[i] = 0;
      m_be[i] = 0; m_op[i] = 0; m_at[i] = 0; at_pat[i] = 8'h00;
    end
    clear_stats();
    @(negedge clk);
    do_reset();
    cycle();
    check("reset_grant", 32'(grant), 32'd0);

    // Single m0 read, ack on the second bus cycle.
    clear_stats(); auto_mode = 1; fix_rd = 1; ack_delay = 1;
    m_addr[0] = 32'h100; m_we[0] = 0; m_be[0] = 4'hF; m_op[0] = 7'h00;
    rem[0] = 1;
    run_auto("s1_budget", 20);
    fix_rd = 0;
    check("s1_bus_cycles", 32'(n_bus), 32'd2);
    check("s1_m0_acks", 32'(n_ack[0]), 32'd1);
    check("s1_m0_rd", cap_m0_rd, 32'hDEADBEEF);
    check("s1_m1_acks", 32'(n_ack[1]), 32'd0);

    // Simultaneous requests after reset alternate strictly.
    do_reset();
    clear_stats(); ack_delay = 0;
    m_addr[1] = 32'h400; m_wd[0] = 32'h11; m_wd[1] = 32'h22;
    rem[0] = 4; rem[1] = 4;
    run_auto("s2_budget", 60);
    check("s2_m0_acks", 32'(n_ack[0]), 32'd4);
    check("s2_m1_acks", 32'(n_ack[1]), 32'd4);
    check("s2_grants", 32'(glog.size()), 32'd8);
    for (int i = 0; i < glog.size() && i < 8; i++)
      check("s2_order", 32'(glog[i]), 32'(i % 2));

    // m1 write, m0 request arriving during it stalls until the m1 ack.
    clear_stats(); ack_delay = 2;
    m_we[1] = 1; m_addr[1] = 32'h2000; m_wd[1] = 32'h12345678; m_be[1] = 4'b0011;
    m_op[1] = 7'h05;
    rem[1] = 1;
    drive_auto(); cycle();
    rem[0] = 1;
    run_auto("s3_budget", 40);
    check("s3_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("s3_first", 32'(glog[0]), 32'd1);
      check("s3_second", 32'(glog[1]), 32'd0);
    end
    check("s3_we", 32'(cap_we), 32'd1);
    check("s3_addr", cap_addr, 32'h2000);
    check("s3_wdata", cap_wd, 32'h12345678);
    check("s3_be", 32'(cap_be), 32'd3);

    // Watchdog: slave never acks; m0 aborted on its 8th owned cycle.
    clear_stats(); ack_delay = -1;
    m_we[1] = 0;
    rem[0] = 1;
    drive_auto(); cycle();
    rem[1] = 1;
    run_auto("s4_budget", 60);
    check("s4_m0_err", 32'(n_err[0]), 32'd1);
    check("s4_err_cycle", 32'(err_len0), 32'(TO));
    check("s4_err_bus_en", 32'(err_bus), 32'd0);
    check("s4_m1_err", 32'(n_err[1]), 32'd1);
    check("s4_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) check("s4_next", 32'(glog[1]), 32'd1);

    // Atomic lock: m1 LR, SC, then a plain access; m0 waits throughout.
    clear_stats(); ack_delay = 1;
    at_pat[1] = 8'b0000_0011; m_op[1] = 7'h02;
    rem[1] = 3;
    drive_auto(); cycle();
    rem[0] = 1;
    run_auto("s5_budget", 60);
    check("s5_m1_acks", 32'(n_ack[1]), 32'd3);
    check("s5_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) check("s5_then_m0", 32'(glog[1]), 32'd0);
    at_pat[1] = 8'h00;

    // Reset while m0 owns the bus; the late ack must go nowhere.
    clear_stats(); ack_delay = -1;
    rem[0] = 1;
    drive_auto(); cycle();
    drive_auto(); cycle();
    drive_auto(); rst = 1; ack = 1; cycle();
    rst = 0; rem[0] = 0;
    drive_auto(); ack = 1; cycle();
    check("s6_m0_acks", 32'(n_ack[0]), 32'd0);
    check("s6_m1_acks", 32'(n_ack[1]), 32'd0);
    check("s6_grant", 32'(grant), 32'd0);

    // Randomized traffic, including drops, timeouts and resets.
    auto_mode = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) m_en[i] = ~m_en[i];
        m_we[i] = 1'($urandom); m_addr[i] = $urandom; m_wd[i] = $urandom;
        m_be[i] = 4'($urandom); m_op[i] = 7'($urandom); m_at[i] = 1'($urandom);
      end
      ack = ($urandom_range(0, 4) == 0);
      rd  = $urandom;
      rst = ($urandom_range(0, 79) == 0);
      cycle();
    end
    rst = 0; ack = 0;
    for (int i = 0; i < 2; i++) m_en[i] = 0;
    cycle(); cycle();
    check("end_grant", 32'(grant), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
